// File: rtl/altr_hps_demux14_deser_if.sv
// Beat-in / frame-out bus for the 1:4 lane distributor.
// The master is the side that drives beats and frame acceptance (link + consumer).
// The slave is the distributor itself.
interface altr_hps_demux14_deser_if #(
    parameter int DW = 8
);
    logic [DW-1:0] din;
    logic          din_vld;
    logic          din_sof;
    logic          din_rdy;
    logic [DW-1:0] dout0;
    logic [DW-1:0] dout1;
    logic [DW-1:0] dout2;
    logic [DW-1:0] dout3;
    logic          dout_vld;
    logic          dout_rdy;
    logic [1:0]    slot;
    logic          err_trunc;

    modport master (
        output din, din_vld, din_sof, dout_rdy,
        input  din_rdy, dout0, dout1, dout2, dout3, dout_vld, slot, err_trunc
    );

    modport slave (
        input  din, din_vld, din_sof, dout_rdy,
        output din_rdy, dout0, dout1, dout2, dout3, dout_vld, slot, err_trunc
    );
endinterface

// File: rtl/altr_hps_demux14_deser.sv
// 1-to-4 lane distributor: successive accepted beats fill lanes 0..3.
// A registered 4-lane frame is then presented with valid/ready.
// An SOF beat always restarts the frame at lane 0.
// A partially staged frame that an SOF beat overrides is reported with err_trunc.
module altr_hps_demux14_deser #(
    parameter int DW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    altr_hps_demux14_deser_if.slave bus
);
    typedef enum logic [1:0] {FILL0 = 2'd0, FILL1 = 2'd1, FILL2 = 2'd2, FILL3 = 2'd3} fill_t;

    fill_t         r_slot;
    logic [DW-1:0] r_st0, r_st1, r_st2;
    logic [DW-1:0] r_dout0, r_dout1, r_dout2, r_dout3;
    logic          r_dout_vld;
    logic          r_err_trunc;

    logic w_din_rdy;
    logic w_acc;
    logic w_take;

    // Only the frame-completing beat can stall, and only while the held frame is not leaving.
    assign w_din_rdy = (r_slot != FILL3) || bus.din_sof || !r_dout_vld || bus.dout_rdy;
    assign w_acc     = bus.din_vld && w_din_rdy;
    assign w_take    = r_dout_vld && bus.dout_rdy;

    assign bus.din_rdy   = w_din_rdy;
    assign bus.dout0     = r_dout0;
    assign bus.dout1     = r_dout1;
    assign bus.dout2     = r_dout2;
    assign bus.dout3     = r_dout3;
    assign bus.dout_vld  = r_dout_vld;
    assign bus.slot      = r_slot;
    assign bus.err_trunc = r_err_trunc;

    // Fill state machine, staging registers, and output frame register.
    // A completing frame overrides the consumer's clear, so back-to-back frames have no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot      <= FILL0;
            r_st0       <= '0;
            r_st1       <= '0;
            r_st2       <= '0;
            r_dout0     <= '0;
            r_dout1     <= '0;
            r_dout2     <= '0;
            r_dout3     <= '0;
            r_dout_vld  <= 1'b0;
            r_err_trunc <= 1'b0;
        end else begin
            r_err_trunc <= 1'b0;
            if (w_take)
                r_dout_vld <= 1'b0;
            if (w_acc) begin
                if (bus.din_sof) begin
                    r_st0  <= bus.din;
                    r_slot <= FILL1;
                    if (r_slot != FILL0)
                        r_err_trunc <= 1'b1;
                end else begin
                    case (r_slot)
                        FILL0: begin
                            r_st0  <= bus.din;
                            r_slot <= FILL1;
                        end
                        FILL1: begin
                            r_st1  <= bus.din;
                            r_slot <= FILL2;
                        end
                        FILL2: begin
                            r_st2  <= bus.din;
                            r_slot <= FILL3;
                        end
                        default: begin
                            r_dout0    <= r_st0;
                            r_dout1    <= r_st1;
                            r_dout2    <= r_st2;
                            r_dout3    <= bus.din;
                            r_dout_vld <= 1'b1;
                            r_slot     <= FILL0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_altr_hps_demux14_deser.sv
// Randomized bench for the 1:4 lane distributor.
// Reference model: a queue of staged beats, plus a held output frame.
module tb_altr_hps_demux14_deser;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    altr_hps_demux14_deser_if #(.DW(DW)) bus ();
    altr_hps_demux14_deser #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [DW-1:0] stg[$];
    logic [DW-1:0] hframe[4];
    bit            held;
    bit            exp_err;
    int            err_pulses;
    int            frames_made;
    int            frames_taken;

    task automatic model_clear();
        stg.delete();
        held    = 0;
        exp_err = 0;
        for (int i = 0; i < 4; i++) hframe[i] = '0;
    endtask

    // One clock: drive, check din_rdy, advance the model, then check the registered outputs.
    task automatic cycle(input bit vld, input bit sof, input logic [DW-1:0] d, input bit rdy, output bit acc);
        bit exp_rdy;
        @(negedge clk);
        bus.din_vld  = vld;
        bus.din_sof  = sof;
        bus.din      = d;
        bus.dout_rdy = rdy;
        #1;
        exp_rdy = (stg.size() != 3) || sof || !held || rdy;
        checks++;
        if (bus.din_rdy !== exp_rdy) begin
            errors++;
            $display("FAIL din_rdy: got %b want %b (staged=%0d held=%0b)", bus.din_rdy, exp_rdy, stg.size(), held);
        end
        acc = vld && exp_rdy;
        exp_err = 0;
        if (held && rdy) begin
            held = 0;
            frames_taken++;
        end
        if (acc) begin
            if (sof) begin
                if (stg.size() != 0) exp_err = 1;
                stg.delete();
            end
            stg.push_back(d);
            if (stg.size() == 4) begin
                for (int i = 0; i < 4; i++) hframe[i] = stg[i];
                held = 1;
                frames_made++;
                stg.delete();
            end
        end
        @(posedge clk);
        #1;
        if (bus.err_trunc === 1'b1) err_pulses++;
        checks++;
        if (bus.slot !== 2'(stg.size())) begin
            errors++;
            $display("FAIL slot: got %0d want %0d", bus.slot, stg.size());
        end
        checks++;
        if (bus.dout_vld !== held) begin
            errors++;
            $display("FAIL dout_vld: got %b want %b", bus.dout_vld, held);
        end
        checks++;
        if (bus.err_trunc !== exp_err) begin
            errors++;
            $display("FAIL err_trunc: got %b want %b", bus.err_trunc, exp_err);
        end
        if (held) begin
            checks++;
            if ({bus.dout0, bus.dout1, bus.dout2, bus.dout3} !== {hframe[0], hframe[1], hframe[2], hframe[3]}) begin
                errors++;
                $display("FAIL lanes: got %h %h %h %h want %h %h %h %h", bus.dout0, bus.dout1, bus.dout2, bus.dout3,
                         hframe[0], hframe[1], hframe[2], hframe[3]);
            end
        end
    endtask

    // Retries a beat until it is accepted, with a bounded number of tries.
    // rdy is the consumer ready that is used while the beat is waiting.
    task automatic send(input logic [DW-1:0] d, input bit sof, input bit rdy);
        bit acc;
        int n;
        n = 0;
        do begin
            cycle(1'b1, sof, d, rdy, acc);
            n++;
        end while (!acc && n < 20);
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: beat %h not accepted after %0d cycles", d, n);
        end
    endtask

    task automatic idle(input bit rdy);
        bit acc;
        cycle(1'b0, 1'b0, '0, rdy, acc);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.din_vld = 1'b0;
        bus.din_sof = 1'b0;
        bus.dout_rdy = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.dout0, bus.dout1, bus.dout2, bus.dout3, bus.dout_vld, bus.slot, bus.err_trunc} !== '0) begin
            errors++;
            $display("FAIL reset_state: lanes %h %h %h %h vld %b slot %0d err %b", bus.dout0, bus.dout1, bus.dout2,
                     bus.dout3, bus.dout_vld, bus.slot, bus.err_trunc);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_basic();
        send(8'h11, 1, 1);
        send(8'h22, 0, 1);
        send(8'h33, 0, 1);
        send(8'h44, 0, 1);
        checks++;
        if (bus.dout_vld !== 1'b1 || bus.dout0 !== 8'h11 || bus.dout3 !== 8'h44) begin
            errors++;
            $display("FAIL basic_frame: vld %b d0 %h d3 %h want 1 11 44", bus.dout_vld, bus.dout0, bus.dout3);
        end
        idle(1);
    endtask

    task automatic test_stall();
        bit acc;
        for (int i = 0; i < 7; i++) send(8'(8'h50 + i), i == 0, 0);
        // the eighth beat must stall while the first frame is held
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 8'h57, 1'b0, acc);
            checks++;
            if (acc) begin
                errors++;
                $display("FAIL stall_beat8: got accepted want stalled");
            end
        end
        send(8'h57, 0, 1);
        idle(0);
        idle(1);
    endtask

    task automatic test_sof_trunc();
        int p0;
        p0 = err_pulses;
        send(8'hA0, 1, 1);
        send(8'hA1, 0, 1);
        send(8'hB0, 1, 1);
        send(8'hB1, 0, 1);
        send(8'hB2, 0, 1);
        send(8'hB3, 0, 1);
        checks++;
        if (err_pulses - p0 != 1) begin
            errors++;
            $display("FAIL trunc_pulses: got %0d want 1", err_pulses - p0);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), i == 0, 0);
        for (int i = 0; i < 3; i++) send(8'(8'hD0 + i), i == 0, 0);
        // completing beat and accept of the held frame share a cycle
        send(8'hD3, 0, 1);
        checks++;
        if (bus.dout_vld !== 1'b1 || bus.dout0 !== 8'hD0) begin
            errors++;
            $display("FAIL b2b: vld %b d0 %h want 1 d0", bus.dout_vld, bus.dout0);
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        send(8'h01, 1, 1);
        send(8'h02, 0, 1);
        apply_reset();
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 0, 0);
        apply_reset();
        for (int i = 0; i < 4; i++) send(8'(8'h20 + i), i == 0, 0);
        idle(1);
    endtask

    task automatic test_random();
        int sent;
        int cyc;
        logic [7:0] d;
        bit acc;
        bit v;
        bit s;
        sent = 0;
        cyc = 0;
        d = 8'h00;
        frames_made = 0;
        frames_taken = 0;
        while (sent < 400 && cyc < 4000) begin
            v = ($urandom_range(0, 2) != 0);
            s = ($urandom_range(0, 15) == 0);
            cycle(v, s, d, $urandom_range(0, 3) != 0, acc);
            if (acc) begin
                sent++;
                d = d + 8'd1;
            end
            cyc++;
        end
        checks++;
        if (sent != 400) begin
            errors++;
            $display("FAIL random_progress: got %0d beats want 400", sent);
        end
        idle(1);
        idle(1);
        checks++;
        if (frames_taken != frames_made) begin
            errors++;
            $display("FAIL random_frames: taken %0d made %0d", frames_taken, frames_made);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.din = '0;
        bus.din_vld = 1'b0;
        bus.din_sof = 1'b0;
        bus.dout_rdy = 1'b0;
        err_pulses = 0;
        frames_made = 0;
        frames_taken = 0;
        model_clear();
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_sof_trunc();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
